// File: rtl/bmat_pipe_unit.sv
// bmat_pipe_unit: RISC-V bitmanip bmator/bmatxor/bmatflip coprocessor.
// ROWS_PER_CYCLE rows per cycle; optional rd_ready via BMAT_READY_EN.
// Ports: clock, resetn (sync, active-low), start, mode[1:0],
//   rs1[63:0], rs2[63:0], rd_ready (BMAT_READY_EN only),
//   rd[63:0] (valid while done), busy, done.
module bmat_pipe_unit #(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [63:0] rs1,
    input  logic [63:0] rs2,
`ifdef BMAT_READY_EN
    input  logic        rd_ready,
`endif
    output logic [63:0] rd,
    output logic        busy,
    output logic        done
);

    localparam int R  = ROWS_PER_CYCLE;
    localparam int P  = 8 / R;
    localparam int CW = (P > 1) ? $clog2(P) : 1;

    generate
        if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rows
            $error("ROWS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] a_q, b_q, rd_q, rd_d;
    logic [1:0]  mode_q;
    logic [CW-1:0] cnt_q;
    logic        last_row;
    logic        accept;
    logic        ready_ok;

`ifdef BMAT_READY_EN
    assign ready_ok = rd_ready;
`else
    assign ready_ok = 1'b1;
`endif

    // One result row: combine the rows of B selected by the bits of A's row.
    function automatic logic [7:0] row_calc(input logic [7:0]  a,
                                            input logic [63:0] b,
                                            input logic        use_xor);
        logic [7:0] acc;
        acc = '0;
        for (int k = 0; k < 8; k++) begin
            if (a[k]) begin
                acc = use_xor ? (acc ^ b[8*k +: 8]) : (acc | b[8*k +: 8]);
            end
        end
        return acc;
    endfunction

    function automatic logic [63:0] flip(input logic [63:0] a);
        logic [63:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                t[8*i + j] = a[8*j + i];
            end
        end
        return t;
    endfunction

    generate
        if (P > 1) begin : g_cnt
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    cnt_q <= '0;
                end else if (accept) begin
                    cnt_q <= '0;
                end else if (state_q == RUN) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            assign last_row = (cnt_q == CW'(P - 1));
        end else begin : g_nocnt
            assign cnt_q    = '0;
            assign last_row = 1'b1;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A flip is a single RUN cycle; a new request can start from DONE.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                accept = start;
            end
            RUN: begin
                busy = 1'b1;
                if (mode_q[1] || last_row) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (ready_ok) begin
                    accept  = start;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            state_d = RUN;
        end
    end

    always_comb begin
        int         base;
        logic [2:0] idx;
        rd_d = rd_q;
        base = 0;
        idx  = '0;
        if (state_q == RUN) begin
            if (mode_q[1]) begin
                rd_d = flip(a_q);
            end else begin
                for (int r = 0; r < R; r++) begin
                    base = int'(cnt_q) * R + r;
                    idx  = base[2:0];
                    rd_d[{idx, 3'b000} +: 8] =
                        row_calc(a_q[{idx, 3'b000} +: 8], b_q, mode_q[0]);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            rd_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= '0;
        end else begin
            rd_q <= rd_d;
            if (accept) begin
                a_q    <= rs1;
                b_q    <= rs2;
                mode_q <= mode;
            end
        end
    end

    assign rd = rd_q;

endmodule

// File: tb/tb_bmat_pipe_unit.sv
// tb_bmat_pipe_unit: scoreboard bench for bmat_pipe_unit.
// Four instances (R = 1, 2, 4, 8) share operands; one is driven at a time.
module tb_bmat_pipe_unit;

    logic        clock = 1'b0;
    logic        resetn;
    logic [3:0]  start_w;
    logic [1:0]  mode;
    logic [63:0] rs1, rs2;
    logic        rd_ready;
    logic [63:0] rd_w [4];
    logic [3:0]  busy_w, done_w;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sel      = 0;

    typedef struct {
        logic [63:0] rd;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bmat_pipe_unit #(.ROWS_PER_CYCLE(1 << g)) u_dut (
            .clock   (clock),
            .resetn  (resetn),
            .start   (start_w[g]),
            .mode    (mode),
            .rs1     (rs1),
            .rs2     (rs2),
`ifdef BMAT_READY_EN
            .rd_ready(rd_ready),
`endif
            .rd      (rd_w[g]),
            .busy    (busy_w[g]),
            .done    (done_w[g])
        );
    end

    task automatic check64(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bit-level reference, independent of any row structure.
    function automatic logic [63:0] model(input logic [1:0] m,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
        logic [63:0] r;
        logic        acc, t;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (m[1]) begin
                    r[8*i + j] = a[8*j + i];
                end else begin
                    acc = 1'b0;
                    for (int k = 0; k < 8; k++) begin
                        t   = a[8*i + k] & b[8*k + j];
                        acc = m[0] ? (acc ^ t) : (acc | t);
                    end
                    r[8*i + j] = acc;
                end
            end
        end
        return r;
    endfunction

    function automatic int lat(input int g, input logic [1:0] m);
        return m[1] ? 1 : (8 >> g);
    endfunction

    // Pops one expectation on every rising done of any instance.
    logic [3:0] done_prev = 4'b0;
    always @(negedge clock) begin
        exp_t e;
        for (int g = 0; g < 4; g++) begin
            if (done_w[g] && !done_prev[g]) begin
                chk_int("done_expected",
                        (g == sel && exp_q.size() != 0) ? 1 : 0, 1);
                if (g == sel && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check64("sb_rd", rd_w[g], e.rd);
                    chk_int("sb_latency", cyc, e.due);
                end
            end
        end
        done_prev <= done_w;
    end

    task automatic issue(input int g, input logic [1:0] m,
                         input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        e.rd  = model(m, a, b);
        e.due = cyc + 1 + lat(g, m);
        exp_q.push_back(e);
        sel        = g;
        start_w    = 4'b0;
        start_w[g] = 1'b1;
        mode       = m;
        rs1        = a;
        rs2        = b;
        @(negedge clock);
        start_w = 4'b0;
        mode    = 2'($urandom);
        rs1     = ~a;
        rs2     = ~b;
    endtask

    task automatic wait_done(input int g, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (done_w[g]) return;
        end
        chk_int("done_timeout", 0, 1);
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (exp_q.size() == 0) begin
                @(negedge clock);
                return;
            end
            @(negedge clock);
        end
        chk_int("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] a, b, c, d, e;
        logic [1:0]  m;
        resetn   = 1'b0;
        start_w  = 4'b0;
        mode     = 2'b00;
        rs1      = '0;
        rs2      = '0;
        rd_ready = 1'b1;
        repeat (3) @(negedge clock);
        for (int g = 0; g < 4; g++) begin
            check64("rst_rd", rd_w[g], 64'h0);
            chk_int("rst_busy", int'(busy_w[g]), 0);
            chk_int("rst_done", int'(done_w[g]), 0);
        end
        resetn = 1'b1;
        @(negedge clock);

        for (int g = 0; g < 4; g++) begin
            issue(g, 2'b01, 64'h0123456789ABCDEF, 64'h8040201008040201);
            wait_done(g, 20);
            check64("identity", rd_w[g], 64'h0123456789ABCDEF);
            drain(20);
        end

        issue(1, 2'b01, 64'h3, 64'h0101);
        wait_done(1, 20);
        check64("xor_cancel", rd_w[1], 64'h0);
        drain(20);
        issue(1, 2'b00, 64'h3, 64'h0101);
        wait_done(1, 20);
        check64("or_keep", rd_w[1], 64'h1);
        drain(20);

        for (int g = 0; g < 4; g++) begin
            issue(g, 2'b10, 64'hFF, {$urandom, $urandom});
            wait_done(g, 20);
            check64("flip", rd_w[g], 64'h0101010101010101);
            drain(20);
        end
        issue(0, 2'b11, 64'h8000000000000001, 64'h0);
        wait_done(0, 20);
        check64("mode11_flip", rd_w[0], 64'h8000000000000001);
        drain(20);

        for (int g = 0; g < 4; g++) begin
            for (int n = 0; n < 250; n++) begin
                m = 2'($urandom);
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                issue(g, m, a, b);
                if (n != 249) wait_done(g, 20);
            end
            drain(40);
        end

        a = 64'h1234F00DCAFE5A5A;
        b = 64'h0F1E2D3C4B5A6978;
        issue(0, 2'b00, a, b);
        repeat (2) @(negedge clock);
        chk_int("run_busy", int'(busy_w[0]), 1);
        start_w[0] = 1'b1;
        mode       = 2'b01;
        rs1        = '1;
        @(negedge clock);
        start_w = 4'b0;
        wait_done(0, 20);
        check64("midrun_ignore", rd_w[0], model(2'b00, a, b));
        repeat (12) @(negedge clock);
        drain(20);

        sel        = 0;
        start_w[0] = 1'b1;
        mode       = 2'b01;
        rs1        = 64'hFFFF0000FFFF0000;
        rs2        = 64'h00FF00FF00FF00FF;
        @(negedge clock);
        start_w = 4'b0;
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        check64("abort_rd", rd_w[0], 64'h0);
        chk_int("abort_busy", int'(busy_w[0]), 0);
        repeat (12) @(negedge clock);
        chk_int("abort_nodone", int'(done_w[0]), 0);
        check64("abort_rd_hold", rd_w[0], 64'h0);
        issue(0, 2'b01, 64'h0123456789ABCDEF, 64'h8040201008040201);
        wait_done(0, 20);
        check64("after_abort", rd_w[0], 64'h0123456789ABCDEF);
        drain(20);

`ifdef BMAT_READY_EN
        a = 64'hDEADBEEF01234567;
        b = 64'h7766554433221100;
        e = model(2'b01, a, b);
        rd_ready = 1'b0;
        issue(0, 2'b01, a, b);
        wait_done(0, 20);
        for (int n = 0; n < 5; n++) begin
            chk_int("bp_done", int'(done_w[0]), 1);
            chk_int("bp_busy", int'(busy_w[0]), 0);
            check64("bp_rd", rd_w[0], e);
            start_w[0] = 1'b1;
            mode       = 2'b00;
            rs1        = ~a;
            @(negedge clock);
        end
        start_w  = 4'b0;
        rd_ready = 1'b1;
        c = 64'h00000000000000F0;
        d = 64'hFFFFFFFFFFFFFFFF;
        issue(0, 2'b00, c, d);
        wait_done(0, 20);
        check64("bp_next", rd_w[0], model(2'b00, c, d));
        drain(20);
`endif

        drain(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
